// File: rtl/snoop_bus_sequencer.sv
// Snoop bus sequencer: round-robin arbitration between two L1 controllers, then broadcast, snoop, optional memory fill and response.
// Optional memory-wait timeout enabled by defining BUS_TIMEOUT_EN.
module snoop_bus_sequencer #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req1,
  input  logic              req2,
  input  logic [1:0]        op1,
  input  logic [1:0]        op2,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  output logic              gnt1,
  output logic              gnt2,
  output logic              snoop_valid1,
  output logic              snoop_valid2,
  output logic [1:0]        snoop_op,
  output logic [ADDR_W-1:0] snoop_addr,
  input  logic              snoop_hit1,
  input  logic              snoop_hit2,
  input  logic [DATA_W-1:0] snoop_data1,
  input  logic [DATA_W-1:0] snoop_data2,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid1,
  output logic              resp_valid2,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_shared,
  output logic              resp_err
);

  localparam logic [1:0] OP_UPGR = 2'b01;
  localparam logic [1:0] OP_NONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNOOP = 2'd1,
    MEM   = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state;
  logic                rr_ptr;
  logic                owner_q;   // 0: core1 owns the bus, 1: core2
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                hit_q;

  logic                valid1_c;
  logic                valid2_c;
  logic                win2_c;
  logic [1:0]          win_op_c;
  logic [ADDR_W-1:0]   win_addr_c;
  logic                hit_c;
  logic [DATA_W-1:0]   sdata_c;
  logic                timeout_c;

  assign valid1_c   = req1 && (op1 != OP_NONE);
  assign valid2_c   = req2 && (op2 != OP_NONE);
  assign win2_c     = valid2_c && (!valid1_c || rr_ptr);
  assign win_op_c   = win2_c ? op2 : op1;
  assign win_addr_c = win2_c ? addr2 : addr1;

  // The snooped core is always the one that does not own the bus.
  assign hit_c   = owner_q ? snoop_hit1  : snoop_hit2;
  assign sdata_c = owner_q ? snoop_data1 : snoop_data2;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] wait_cnt;

  assign timeout_c = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Saturating count of MEM cycles without data; zero whenever outside MEM.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      resp_err <= 1'b0;
    end else begin
      resp_err <= (state == MEM) && !mem_ready && timeout_c;
      if (state != MEM) begin
        wait_cnt <= '0;
      end else if (!mem_ready && (wait_cnt != '1)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic [31:0] timeout_unused;

  assign timeout_unused = 32'(TIMEOUT_CYCLES);
  assign timeout_c      = 1'b0;
  assign resp_err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= 1'b0;
      owner_q      <= 1'b0;
      op_q         <= '0;
      addr_q       <= '0;
      hit_q        <= 1'b0;
      gnt1         <= 1'b0;
      gnt2         <= 1'b0;
      snoop_valid1 <= 1'b0;
      snoop_valid2 <= 1'b0;
      snoop_op     <= '0;
      snoop_addr   <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      resp_valid1  <= 1'b0;
      resp_valid2  <= 1'b0;
      resp_data    <= '0;
      resp_shared  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid1_c || valid2_c) begin
            state        <= SNOOP;
            owner_q      <= win2_c;
            op_q         <= win_op_c;
            addr_q       <= win_addr_c;
            rr_ptr       <= !win2_c;
            gnt1         <= !win2_c;
            gnt2         <= win2_c;
            snoop_valid1 <= win2_c;
            snoop_valid2 <= !win2_c;
            snoop_op     <= win_op_c;
            snoop_addr   <= win_addr_c;
          end
        end

        SNOOP: begin
          hit_q        <= hit_c;
          snoop_valid1 <= 1'b0;
          snoop_valid2 <= 1'b0;
          snoop_op     <= '0;
          snoop_addr   <= '0;
          if ((op_q == OP_UPGR) || hit_c) begin
            state       <= RESP;
            resp_valid1 <= !owner_q;
            resp_valid2 <= owner_q;
            // An upgrade only needs ownership; no data or sharing is reported.
            resp_data   <= (op_q == OP_UPGR) ? '0 : sdata_c;
            resp_shared <= (op_q != OP_UPGR) && hit_c;
          end else begin
            state    <= MEM;
            mem_req  <= 1'b1;
            mem_addr <= addr_q;
          end
        end

        MEM: begin
          if (mem_ready) begin
            state       <= RESP;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            resp_valid1 <= !owner_q;
            resp_valid2 <= owner_q;
            resp_data   <= mem_rdata;
            resp_shared <= hit_q;
          end else if (timeout_c) begin
            state       <= RESP;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            resp_valid1 <= !owner_q;
            resp_valid2 <= owner_q;
            resp_data   <= '0;
            resp_shared <= 1'b0;
          end
        end

        RESP: begin
          state       <= IDLE;
          gnt1        <= 1'b0;
          gnt2        <= 1'b0;
          resp_valid1 <= 1'b0;
          resp_valid2 <= 1'b0;
          resp_data   <= '0;
          resp_shared <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_bus_sequencer.sv
// Bench for snoop_bus_sequencer: transaction-level model checked every cycle plus directed literal expectations.
module tb_snoop_bus_sequencer;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 64;
`endif

  logic          clk;
  logic          reset;
  logic          req1, req2;
  logic [1:0]    op1, op2;
  logic [AW-1:0] addr1, addr2;
  logic          gnt1, gnt2;
  logic          snoop_valid1, snoop_valid2;
  logic [1:0]    snoop_op;
  logic [AW-1:0] snoop_addr;
  logic          snoop_hit1, snoop_hit2;
  logic [DW-1:0] snoop_data1, snoop_data2;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          resp_valid1, resp_valid2;
  logic [DW-1:0] resp_data;
  logic          resp_shared;
  logic          resp_err;

  snoop_bus_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req1(req1), .req2(req2), .op1(op1), .op2(op2), .addr1(addr1), .addr2(addr2),
    .gnt1(gnt1), .gnt2(gnt2),
    .snoop_valid1(snoop_valid1), .snoop_valid2(snoop_valid2),
    .snoop_op(snoop_op), .snoop_addr(snoop_addr),
    .snoop_hit1(snoop_hit1), .snoop_hit2(snoop_hit2),
    .snoop_data1(snoop_data1), .snoop_data2(snoop_data2),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .resp_valid1(resp_valid1), .resp_valid2(resp_valid2),
    .resp_data(resp_data), .resp_shared(resp_shared), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: tracks the open transaction and what each output must show next cycle.
  bit            model_live = 1'b0;
  bit            m_busy, m_snoop, m_wait, m_rr, m_w2;
  logic [1:0]    m_op;
  logic [AW-1:0] m_addr;
  int            m_waits;
  logic          m_v1, m_v2, m_hit;
  logic [DW-1:0] m_d;
  logic          e_gnt1, e_gnt2, e_sv1, e_sv2, e_mreq, e_rv1, e_rv2, e_shared, e_err;
  logic [1:0]    e_sop;
  logic [AW-1:0] e_saddr, e_maddr;
  logic [DW-1:0] e_rdata;

  task automatic clear_all();
    e_gnt1 = 0; e_gnt2 = 0; e_sv1 = 0; e_sv2 = 0; e_mreq = 0; e_rv1 = 0; e_rv2 = 0;
    e_shared = 0; e_err = 0; e_sop = '0; e_saddr = '0; e_maddr = '0; e_rdata = '0;
  endtask

  task automatic respond(input logic [DW-1:0] d, input logic sh, input logic er);
    e_rv1 = !m_w2; e_rv2 = m_w2; e_rdata = d; e_shared = sh; e_err = er;
  endtask

  always @(posedge clk) begin
    model_live = 1'b1;
    if (reset) begin
      m_busy = 0; m_snoop = 0; m_wait = 0; m_rr = 0;
      clear_all();
    end else if (!m_busy) begin
      clear_all();
      m_v1 = req1 && (op1 != 2'b11);
      m_v2 = req2 && (op2 != 2'b11);
      if (m_v1 || m_v2) begin
        m_w2    = m_v2 && (!m_v1 || m_rr);
        m_rr    = !m_w2;
        m_op    = m_w2 ? op2 : op1;
        m_addr  = m_w2 ? addr2 : addr1;
        m_busy  = 1; m_snoop = 1;
        e_gnt1  = !m_w2; e_gnt2 = m_w2;
        e_sv1   = m_w2;  e_sv2  = !m_w2;
        e_sop   = m_op;  e_saddr = m_addr;
      end
    end else if (m_snoop) begin
      m_snoop = 0; e_sv1 = 0; e_sv2 = 0; e_sop = '0; e_saddr = '0;
      m_hit = m_w2 ? snoop_hit1 : snoop_hit2;
      m_d   = m_w2 ? snoop_data1 : snoop_data2;
      if (m_op == 2'b01) respond('0, 1'b0, 1'b0);
      else if (m_hit) respond(m_d, 1'b1, 1'b0);
      else begin
        m_wait = 1; m_waits = 0; e_mreq = 1; e_maddr = m_addr;
      end
    end else if (m_wait) begin
      if (mem_ready) begin
        m_wait = 0; e_mreq = 0; e_maddr = '0;
        respond(mem_rdata, 1'b0, 1'b0);
      end
`ifdef BUS_TIMEOUT_EN
      else begin
        m_waits++;
        if (m_waits == TO) begin
          m_wait = 0; e_mreq = 0; e_maddr = '0;
          respond('0, 1'b0, 1'b1);
        end
      end
`endif
    end else begin
      clear_all();
      m_busy = 0;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("gnt1", gnt1, e_gnt1);
      chk("gnt2", gnt2, e_gnt2);
      chk("snoop_valid1", snoop_valid1, e_sv1);
      chk("snoop_valid2", snoop_valid2, e_sv2);
      chk("snoop_op", snoop_op, e_sop);
      chk("snoop_addr", snoop_addr, e_saddr);
      chk("mem_req", mem_req, e_mreq);
      chk("mem_addr", mem_addr, e_maddr);
      chk("resp_valid1", resp_valid1, e_rv1);
      chk("resp_valid2", resp_valid2, e_rv2);
      chk("resp_data", resp_data, e_rdata);
      chk("resp_shared", resp_shared, e_shared);
      chk("resp_err", resp_err, e_err);
    end
  end

  int n_mreq;
  int n_gnt;
  int resp_at;
  logic exp1, exp2;

  initial begin
    reset = 1; req1 = 0; req2 = 0; op1 = 0; op2 = 0; addr1 = 0; addr2 = 0;
    snoop_hit1 = 0; snoop_hit2 = 0; snoop_data1 = 0; snoop_data2 = 0;
    mem_ready = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", {gnt1, gnt2}, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_resp", {resp_valid1, resp_valid2}, 0);
    reset = 0;

    // Core1 BusRd hits in core2
    req1 = 1; op1 = 2'b00; addr1 = 32'h100; snoop_hit2 = 1; snoop_data2 = 32'hDEADBEEF;
    @(negedge clk);
    req1 = 0;
    chk("t1_snoop_valid2", snoop_valid2, 1);
    chk("t1_snoop_addr", snoop_addr, 32'h100);
    chk("t1_gnt1", gnt1, 1);
    chk("t1_mem_req_snoop", mem_req, 0);
    @(negedge clk);
    chk("t1_resp_valid1", resp_valid1, 1);
    chk("t1_resp_data", resp_data, 32'hDEADBEEF);
    chk("t1_resp_shared", resp_shared, 1);
    chk("t1_mem_req_resp", mem_req, 0);
    @(negedge clk);
    chk("t1_gnt1_released", gnt1, 0);

    // Core2 BusRdX misses, memory answers after 3 wait cycles
    req2 = 1; op2 = 2'b10; addr2 = 32'h200; snoop_hit1 = 0; snoop_data1 = 32'hAAAA;
    n_mreq = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) req2 = 0;
      if (i >= 2 && i <= 5) begin
        if (mem_req) n_mreq++;
        chk("t2_mem_addr", mem_addr, 32'h200);
      end
      if (i == 5) begin mem_ready = 1; mem_rdata = 32'h12345678; end
      if (i == 6) begin
        mem_ready = 0;
        chk("t2_mem_req_cycles", n_mreq, 4);
        chk("t2_mem_req_dropped", mem_req, 0);
        chk("t2_resp_valid2", resp_valid2, 1);
        chk("t2_resp_data", resp_data, 32'h12345678);
        chk("t2_resp_shared", resp_shared, 0);
      end
    end
    @(negedge clk);

    // Both cores request continuously after reset: grants alternate
    reset = 1;
    @(negedge clk);
    reset = 0;
    snoop_hit1 = 1; snoop_data1 = 32'h1111; snoop_hit2 = 1; snoop_data2 = 32'h2222;
    req1 = 1; op1 = 2'b00; addr1 = 32'h300;
    req2 = 1; op2 = 2'b00; addr2 = 32'h304;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      exp1 = (((i - 1) % 3) < 2) && ((((i - 1) / 3) % 2) == 0);
      exp2 = (((i - 1) % 3) < 2) && ((((i - 1) / 3) % 2) == 1);
      chk("t3_gnt1_pattern", gnt1, exp1);
      chk("t3_gnt2_pattern", gnt2, exp2);
      if (i == 2) chk("t3_core1_data", resp_data, 32'h2222);
      if (i == 5) chk("t3_core2_data", resp_data, 32'h1111);
      if (i == 12) begin req1 = 0; req2 = 0; end
    end

    // Core1 BusUpgr: no data, no sharing, stray mem_ready ignored
    req1 = 1; op1 = 2'b01; addr1 = 32'h40; snoop_hit2 = 1; snoop_data2 = 32'h5555;
    mem_ready = 1; mem_rdata = 32'h9999;
    @(negedge clk);
    req1 = 0;
    chk("t4_snoop_op", snoop_op, 2'b01);
    chk("t4_snoop_addr", snoop_addr, 32'h40);
    @(negedge clk);
    chk("t4_resp_valid1", resp_valid1, 1);
    chk("t4_resp_data", resp_data, 0);
    chk("t4_resp_shared", resp_shared, 0);
    @(negedge clk);
    chk("t4_snoop_op_gone", snoop_op, 0);
    mem_ready = 0;

    // op=11 is never a request
    req1 = 1; op1 = 2'b11; req2 = 1; op2 = 2'b11;
    n_gnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (gnt1 || gnt2) n_gnt++;
    end
    chk("t4_none_no_grant", n_gnt, 0);
    req1 = 0; req2 = 0; op1 = 2'b00; op2 = 2'b00;
    @(negedge clk);

    // Reset during MEM aborts; a fresh request then completes
    req1 = 1; addr1 = 32'h500; snoop_hit2 = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) req1 = 0;
      if (i == 2) begin chk("t5_mem_req_up", mem_req, 1); reset = 1; end
      if (i == 3) begin
        chk("t5_mem_req_abort", mem_req, 0);
        chk("t5_gnt_abort", gnt1, 0);
        chk("t5_no_resp", resp_valid1, 0);
        reset = 0;
      end
      if (i == 4) chk("t5_no_resp_later", resp_valid1, 0);
    end
    req1 = 1; addr1 = 32'h600; snoop_hit2 = 1; snoop_data2 = 32'h7777;
    @(negedge clk);
    req1 = 0;
    @(negedge clk);
    chk("t5_fresh_resp_valid1", resp_valid1, 1);
    chk("t5_fresh_resp_data", resp_data, 32'h7777);
    @(negedge clk);

`ifdef BUS_TIMEOUT_EN
    // Memory never answers: timeout after TO cycles of mem_req
    req2 = 1; op2 = 2'b00; addr2 = 32'h800; snoop_hit1 = 0;
    n_mreq = 0; resp_at = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) req2 = 0;
      if (mem_req) n_mreq++;
      if (resp_valid2 && resp_at == 0) begin
        resp_at = i;
        chk("t6_resp_err", resp_err, 1);
        chk("t6_resp_data", resp_data, 0);
        chk("t6_resp_shared", resp_shared, 0);
      end
    end
    chk("t6_mem_req_cycles", n_mreq, 8);
    chk("t6_resp_cycle", resp_at, 10);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
